dac_wave_gen: RTL and testbench
===============================

Name: dac_wave_gen

Overview:
Upstream sample source for the IIC DAC write path. It generates an 8-bit waveform (sawtooth, triangle, square or constant) at a programmable update rate. Each new sample is packed into the 16-bit DAC write word, and one iic_drive write is started per sample via a start/ready handshake. It replaces a free-running ramp counter with a rate-controlled, flow-controlled sample stream that has overrun and ack-error reporting.

Parameters:
UPDATE_DIV, 28'd25_000, clock cycles per sample tick (500 us at 50 MHz); legal range 4 and above.
DATA_W, 8, DAC sample width (fixed at 8 for the packing rule below).

Ports:
wave_clk  in  1  system clock
wave_rst  in  1  asynchronous reset, active-low
wave_en  in  1  run enable, level
wave_mode  in  2  0 sawtooth, 1 triangle, 2 square, 3 constant
wave_min  in  8  lower sample bound
wave_max  in  8  upper sample bound
wave_step  in  8  increment per tick (modes 0/1)
iic_ready  in  1  from iic_drive: 1 idle, 0 busy
iic_ack_error  in  1  from iic_drive: ack failure pulse/level
iic_start  out  1  one-cycle write start pulse to iic_drive
iic_wdata  out  16  packed DAC write word
sample  out  8  current sample value
overrun  out  1  sticky: a tick arrived while a transfer was pending
err_cnt  out  8  saturating count of ack errors

Behaviour:
- Reset (async, wave_rst=0): all outputs 0. FSM in IDLE, tick counter 0, direction=up.
- Packing: iic_wdata = {4'b0000, sample[7:4], sample[3:0], 4'b0000}. It updates only in LOAD and is stable through the whole transfer.
- Tick counter: counts 0..UPDATE_DIV-1 while wave_en=1 and wraps. tick=1 for one cycle at UPDATE_DIV-1. The counter is held at 0 while wave_en=0.
- FSM states: IDLE, WAIT_TICK, LOAD, START, WAIT_LOW, WAIT_HIGH.
- IDLE: when wave_en=1, set sample=wave_min and direction=up, go to WAIT_TICK. The first tick transmits the next value, not wave_min.
- WAIT_TICK: on tick go to LOAD. If wave_en=0, go to IDLE.
- LOAD (1 cycle): register the next sample and iic_wdata, go to START.
- START: when iic_ready=1, assert iic_start for exactly 1 cycle and go to WAIT_LOW. Otherwise hold.
  - Latency: tick at cycle T gives the sample update at T+1 and iic_start at T+2 if ready.
- WAIT_LOW: wait for iic_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for iic_ready=1, then go to WAIT_TICK, or to IDLE if wave_en=0.
- Disable mid-transfer: the transfer always completes (no abort), then the FSM goes to IDLE.
- Next-sample rules (9-bit intermediate sums, no 8-bit overflow):
  - Degenerate bounds (wave_min >= wave_max): sample = wave_min in every mode.
  - mode 0: if sample+step > max, sample = min; else sample += step.
  - mode 1, direction up: if sample+step >= max, sample = max and direction = down; else sample += step.
  - mode 1, direction down: if sample < min+step or sample-step <= min, sample = min and direction = up; else sample -= step.
  - mode 2: if sample == max, sample = min; else sample = max.
  - mode 3: sample = wave_min.
  - wave_step = 0: sample is unchanged in modes 0/1.
  - A mode or bound change takes effect at the next LOAD. If the current sample lies outside [min,max], it is first clamped into range, then the rule is applied.
- overrun: set when tick=1 in any state other than WAIT_TICK/IDLE. The tick is dropped and no queueing occurs. Cleared only by wave_en=0 or reset.
- err_cnt: increments by 1 on each cycle where iic_ack_error=1 and state is WAIT_LOW or WAIT_HIGH (iic_drive gives a 1-cycle pulse). Saturates at 255. The sample is not retried. Cleared only by reset.

Test Plan:
- Reset and enable, UPDATE_DIV=8, mode0, min=0x70, max=0x80, step=4, instant-ready bench model -> samples 0x74, 0x78, 0x7C, 0x80, 0x70. First word iic_wdata=0x0740. Exactly one iic_start per sample.
- Triangle: min=0x10, max=0x20, step=6 -> 0x16, 0x1C, 0x20, 0x1A, 0x14, 0x10, 0x16.
- Square, then mode 3 mid-run: min=0x00, max=0xFF -> 0xFF, 0x00, 0xFF; after the switch, 0x00 held. Degenerate min=0x50, max=0x40 -> constant 0x50.
- Slow slave: iic_ready held low for 20 cycles per transfer, UPDATE_DIV=8 -> overrun=1, no second iic_start before ready returns high, iic_wdata stable during busy.
- Ack error: iic_ack_error pulsed on 3 transfers -> err_cnt=3. Force 300 errors -> err_cnt=255.
- wave_en dropped during WAIT_LOW -> transfer completes, FSM reaches IDLE, no further iic_start. Async reset asserted mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/dac_wave_gen.sv
// ---------------------------------------------------------------------------
// dac_wave_gen
//
// Sample source for the IIC DAC write path. Produces an 8-bit waveform
// (sawtooth, triangle, square or constant) at a rate set by UPDATE_DIV.
// Each new sample is packed into the 16-bit DAC write word, and one
// iic_drive write is launched per sample through a start/ready handshake.
// Ticks that arrive while a transfer is still in flight are dropped and
// flagged through the sticky overrun bit. Ack failures reported by iic_drive
// during a transfer are counted in a saturating counter.
//
// Ports:
//   wave_clk       in   system clock
//   wave_rst       in   asynchronous reset, active-low
//   wave_en        in   run enable (level)
//   wave_mode      in   0 sawtooth, 1 triangle, 2 square, 3 constant
//   wave_min       in   lower sample bound
//   wave_max       in   upper sample bound
//   wave_step      in   increment per tick (sawtooth / triangle)
//   iic_ready      in   iic_drive status: 1 idle, 0 busy
//   iic_ack_error  in   iic_drive ack failure pulse/level
//   iic_start      out  one-cycle write start pulse to iic_drive
//   iic_wdata      out  packed DAC write word {4'h0, sample, 4'h0}
//   sample         out  current sample value
//   overrun        out  sticky: a tick arrived while a transfer was pending
//   err_cnt        out  saturating count of ack errors
// ---------------------------------------------------------------------------
module dac_wave_gen #(
   parameter logic [27:0] UPDATE_DIV = 28'd25_000,
   parameter int          DATA_W     = 8
) (
   input  logic              wave_clk,
   input  logic              wave_rst,
   input  logic              wave_en,
   input  logic [1:0]        wave_mode,
   input  logic [DATA_W-1:0] wave_min,
   input  logic [DATA_W-1:0] wave_max,
   input  logic [DATA_W-1:0] wave_step,
   input  logic              iic_ready,
   input  logic              iic_ack_error,
   output logic              iic_start,
   output logic [15:0]       iic_wdata,
   output logic [DATA_W-1:0] sample,
   output logic              overrun,
   output logic [7:0]        err_cnt
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_TICK = 3'd1;
   localparam logic [2:0] ST_LOAD      = 3'd2;
   localparam logic [2:0] ST_START     = 3'd3;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   localparam logic [1:0] MODE_SAW    = 2'd0;
   localparam logic [1:0] MODE_TRI    = 2'd1;
   localparam logic [1:0] MODE_SQUARE = 2'd2;

   localparam logic [27:0] TICK_LAST = UPDATE_DIV - 28'd1;

   logic [2:0]        state_q, state_d;
   logic [27:0]       tick_cnt_q, tick_cnt_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              dir_down_q, dir_down_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              overrun_q, overrun_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              tick;
   logic              in_transfer;
   logic [DATA_W-1:0] next_sample;
   logic              next_dir_down;

   // -----------------------------------------------------------------------
   // Next-sample computation. All sums are done at 9 bits so that a large
   // step can never wrap around an 8-bit boundary. The current sample is
   // first clamped into [min,max] so that a bound change made mid-run
   // behaves sensibly at the next LOAD.
   // -----------------------------------------------------------------------
   function automatic logic [DATA_W:0] calc_next(
      input logic [DATA_W-1:0] cur,
      input logic              down,
      input logic [1:0]        mode,
      input logic [DATA_W-1:0] mn,
      input logic [DATA_W-1:0] mx,
      input logic [DATA_W-1:0] st
   );
      logic [DATA_W-1:0] clamped;
      logic [DATA_W:0]   up_sum;
      logic [DATA_W:0]   min_plus_step;
      logic [DATA_W-1:0] res;
      logic              res_down;

      res      = mn;
      res_down = down;

      if (cur < mn) begin
         clamped = mn;
      end else if (cur > mx) begin
         clamped = mx;
      end else begin
         clamped = cur;
      end

      up_sum        = {1'b0, clamped} + {1'b0, st};
      min_plus_step = {1'b0, mn} + {1'b0, st};

      if (mn >= mx) begin
         res = mn;
      end else begin
         case (mode)
            MODE_SAW: begin
               if (up_sum > {1'b0, mx}) begin
                  res = mn;
               end else begin
                  res = up_sum[DATA_W-1:0];
               end
            end
            MODE_TRI: begin
               if (!down) begin
                  if (up_sum >= {1'b0, mx}) begin
                     res      = mx;
                     res_down = 1'b1;
                  end else begin
                     res = up_sum[DATA_W-1:0];
                  end
               end else begin
                  // The first term guards the subtraction against underflow.
                  if (({1'b0, clamped} < min_plus_step) ||
                      ((clamped - st) <= mn)) begin
                     res      = mn;
                     res_down = 1'b0;
                  end else begin
                     res = clamped - st;
                  end
               end
            end
            MODE_SQUARE: begin
               if (clamped == mx) begin
                  res = mn;
               end else begin
                  res = mx;
               end
            end
            default: begin
               res = mn;
            end
         endcase
      end

      return {res_down, res};
   endfunction

   always_comb begin
      {next_dir_down, next_sample} = calc_next(sample_q, dir_down_q, wave_mode,
                                               wave_min, wave_max, wave_step);
   end

   // Sample-rate divider: free-runs 0..UPDATE_DIV-1 while enabled, held at 0
   // otherwise, so the first tick comes UPDATE_DIV cycles after enable.
   always_comb begin
      tick = wave_en && (tick_cnt_q == TICK_LAST);
      if (!wave_en || tick) begin
         tick_cnt_d = 28'd0;
      end else begin
         tick_cnt_d = tick_cnt_q + 28'd1;
      end
   end

   // Main sequencer. A transfer, once loaded, always runs to completion even
   // if the enable drops; the enable is only re-examined between samples.
   always_comb begin
      state_d    = state_q;
      sample_d   = sample_q;
      dir_down_d = dir_down_q;
      wdata_d    = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (wave_en) begin
               sample_d   = wave_min;
               dir_down_d = 1'b0;
               state_d    = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (!wave_en) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            sample_d   = next_sample;
            dir_down_d = next_dir_down;
            wdata_d    = {4'b0000, next_sample[7:4], next_sample[3:0], 4'b0000};
            state_d    = ST_START;
         end
         ST_START: begin
            if (iic_ready) begin
               state_d = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!iic_ready) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (iic_ready) begin
               state_d = wave_en ? ST_WAIT_TICK : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status: overrun latches a dropped tick until the generator is disabled;
   // err_cnt only counts ack errors seen while a transfer is in flight.
   always_comb begin
      in_transfer = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);

      if (!wave_en) begin
         overrun_d = 1'b0;
      end else if (tick && (state_q != ST_WAIT_TICK) && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      if (iic_ack_error && in_transfer && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge wave_clk or negedge wave_rst) begin
      if (!wave_rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= 28'd0;
         sample_q   <= '0;
         dir_down_q <= 1'b0;
         wdata_q    <= 16'h0000;
         overrun_q  <= 1'b0;
         err_cnt_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         sample_q   <= sample_d;
         dir_down_q <= dir_down_d;
         wdata_q    <= wdata_d;
         overrun_q  <= overrun_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // The start pulse is qualified with ready so it lands in the same cycle
   // the sequencer leaves START; it therefore lasts exactly one cycle.
   assign iic_start = (state_q == ST_START) && iic_ready;
   assign iic_wdata = wdata_q;
   assign sample    = sample_q;
   assign overrun   = overrun_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// ---------------------------------------------------------------------------
// tb_dac_wave_gen
//
// Bench for dac_wave_gen with UPDATE_DIV=8. An iic_drive stand-in drops
// ready for a configurable number of cycles after each start and can inject
// ack errors. Expected samples come from a behavioural waveform model and
// are queued when a run is configured; a monitor pops one per start pulse.
// ---------------------------------------------------------------------------
module tb_dac_wave_gen;

   localparam logic [27:0] DIV = 28'd8;

   logic        wave_clk = 1'b0;
   logic        wave_rst;
   logic        wave_en;
   logic [1:0]  wave_mode;
   logic [7:0]  wave_min;
   logic [7:0]  wave_max;
   logic [7:0]  wave_step;
   logic        iic_ready;
   logic        iic_ack_error;
   logic        iic_start;
   logic [15:0] iic_wdata;
   logic [7:0]  sample;
   logic        overrun;
   logic [7:0]  err_cnt;

   int          total = 0;
   int          bad = 0;
   int          start_cnt = 0;
   int          busy_len = 2;
   int          ack_pulses = 0;
   bit          ack_level = 1'b0;
   logic [7:0]  exp_q[$];
   logic [15:0] last_wdata = 16'h0000;
   int          m_cur;
   bit          m_down;

   dac_wave_gen #(.UPDATE_DIV(DIV), .DATA_W(8)) dut (
      .wave_clk      (wave_clk),
      .wave_rst      (wave_rst),
      .wave_en       (wave_en),
      .wave_mode     (wave_mode),
      .wave_min      (wave_min),
      .wave_max      (wave_max),
      .wave_step     (wave_step),
      .iic_ready     (iic_ready),
      .iic_ack_error (iic_ack_error),
      .iic_start     (iic_start),
      .iic_wdata     (iic_wdata),
      .sample        (sample),
      .overrun       (overrun),
      .err_cnt       (err_cnt)
   );

   always #5 wave_clk = ~wave_clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Waveform model: plain signed integer arithmetic on the textual rules.
   task automatic modelNext(input int mode, input int mn, input int mx, input int st);
      int c;
      if (mn >= mx) begin
         m_cur = mn;
      end else begin
         c = (m_cur < mn) ? mn : ((m_cur > mx) ? mx : m_cur);
         case (mode)
            0: m_cur = (c + st > mx) ? mn : c + st;
            1: begin
               if (!m_down) begin
                  if (c + st >= mx) begin
                     m_cur  = mx;
                     m_down = 1'b1;
                  end else begin
                     m_cur = c + st;
                  end
               end else begin
                  if (c - st <= mn) begin
                     m_cur  = mn;
                     m_down = 1'b0;
                  end else begin
                     m_cur = c - st;
                  end
               end
            end
            2: m_cur = (c == mx) ? mn : mx;
            default: m_cur = mn;
         endcase
      end
      exp_q.push_back(8'(m_cur));
   endtask

   task automatic waitStarts(input int target, input int budget);
      int c = 0;
      while (start_cnt < target && c < budget) begin
         @(posedge wave_clk);
         c++;
      end
      if (start_cnt < target) begin
         checkOutput("start_timeout", start_cnt, target);
      end
   endtask

   // Drop the enable (FSM is in WAIT_LOW here), let the transfer finish and
   // confirm the generator goes quiet with nothing left expected.
   task automatic disableAndDrain(input int target);
      int c = 0;
      #1 wave_en = 1'b0;
      #2;
      while (!iic_ready && c < 1000) begin
         @(posedge wave_clk);
         c++;
      end
      repeat (int'(DIV) * 4) @(posedge wave_clk);
      checkOutput("no_extra_start", start_cnt, target);
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("overrun_cleared", int'(overrun), 0);
      exp_q.delete();
   endtask

   task automatic applyStimulus(input int mode, input int mn, input int mx,
                                input int st, input int n, input int exp_ov);
      int target;
      wave_mode = 2'(mode);
      wave_min  = 8'(mn);
      wave_max  = 8'(mx);
      wave_step = 8'(st);
      m_cur     = mn;
      m_down    = 1'b0;
      for (int i = 0; i < n; i++) modelNext(mode, mn, mx, st);
      target = start_cnt + n;
      @(posedge wave_clk);
      #1 wave_en = 1'b1;
      waitStarts(target, n * (busy_len + int'(DIV) + 20) + 50);
      checkOutput("overrun", int'(overrun), exp_ov);
      disableAndDrain(target);
   endtask

   // iic_drive stand-in.
   initial begin
      iic_ready     = 1'b1;
      iic_ack_error = 1'b0;
      forever begin
         @(posedge wave_clk);
         if (iic_start === 1'b1 && wave_rst === 1'b1) begin
            #1 iic_ready = 1'b0;
            if (ack_level) begin
               iic_ack_error = 1'b1;
            end else if (ack_pulses > 0) begin
               iic_ack_error = 1'b1;
               ack_pulses--;
            end
            for (int i = 0; i < busy_len; i++) begin
               @(posedge wave_clk);
               #1;
               if (!ack_level) iic_ack_error = 1'b0;
            end
            iic_ready     = 1'b1;
            iic_ack_error = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge wave_clk);
         if (wave_rst === 1'b1 && iic_start === 1'b1) begin
            start_cnt++;
            checkOutput("ready_at_start", int'(iic_ready), 1);
            checkOutput("expected_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("sample", int'(sample), int'(e));
               checkOutput("wdata", int'(iic_wdata), int'(e) << 4);
            end
            last_wdata = iic_wdata;
         end else if (wave_rst === 1'b1 && iic_ready === 1'b0) begin
            checkOutput("wdata_stable", int'(iic_wdata), int'(last_wdata));
         end
      end
   end

   initial begin
      int target;
      wave_rst  = 1'b0;
      wave_en   = 1'b0;
      wave_mode = 2'd0;
      wave_min  = 8'h00;
      wave_max  = 8'h00;
      wave_step = 8'h00;
      repeat (3) @(posedge wave_clk);
      #1;
      checkOutput("rst_start", int'(iic_start), 0);
      checkOutput("rst_wdata", int'(iic_wdata), 0);
      checkOutput("rst_sample", int'(sample), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      checkOutput("rst_err_cnt", int'(err_cnt), 0);
      wave_rst = 1'b1;

      $display("[TB] sawtooth");
      busy_len = 2;
      applyStimulus(0, 8'h70, 8'h80, 4, 5, 0);

      $display("[TB] triangle");
      applyStimulus(1, 8'h10, 8'h20, 6, 7, 0);

      $display("[TB] square then constant");
      wave_mode = 2'd2;
      wave_min  = 8'h00;
      wave_max  = 8'hFF;
      wave_step = 8'h01;
      m_cur     = 0;
      m_down    = 1'b0;
      for (int i = 0; i < 3; i++) modelNext(2, 0, 255, 1);
      target = start_cnt + 3;
      @(posedge wave_clk);
      #1 wave_en = 1'b1;
      waitStarts(target, 200);
      #1 wave_mode = 2'd3;
      for (int i = 0; i < 3; i++) modelNext(3, 0, 255, 1);
      target = start_cnt + 3;
      waitStarts(target, 200);
      disableAndDrain(target);

      $display("[TB] degenerate bounds");
      applyStimulus(1, 8'h50, 8'h40, 8, 4, 0);

      $display("[TB] slow slave");
      busy_len = 20;
      applyStimulus(0, 8'h00, 8'hF0, 8'h30, 4, 1);

      $display("[TB] ack pulses");
      busy_len   = 3;
      ack_pulses = 3;
      applyStimulus(1, 8'h20, 8'h90, 8'h11, 4, 0);
      checkOutput("err_cnt_three", int'(err_cnt), 3);

      $display("[TB] ack saturation");
      busy_len  = 300;
      ack_level = 1'b1;
      applyStimulus(0, 8'h00, 8'hFF, 1, 1, 0);
      ack_level = 1'b0;
      checkOutput("err_cnt_sat", int'(err_cnt), 255);

      $display("[TB] random runs");
      for (int r = 0; r < 8; r++) begin
         busy_len = int'($urandom_range(1, 3));
         applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                       int'($urandom_range(4, 10)), 0);
      end

      $display("[TB] async reset mid-transfer");
      busy_len  = 20;
      wave_mode = 2'd0;
      wave_min  = 8'h00;
      wave_max  = 8'hFF;
      wave_step = 8'h10;
      m_cur     = 0;
      m_down    = 1'b0;
      modelNext(0, 0, 255, 16);
      target = start_cnt + 1;
      @(posedge wave_clk);
      #1 wave_en = 1'b1;
      waitStarts(target, 100);
      repeat (3) @(posedge wave_clk);
      #3;
      wave_rst = 1'b0;
      wave_en  = 1'b0;
      #1;
      checkOutput("mid_rst_start", int'(iic_start), 0);
      checkOutput("mid_rst_wdata", int'(iic_wdata), 0);
      checkOutput("mid_rst_sample", int'(sample), 0);
      checkOutput("mid_rst_overrun", int'(overrun), 0);
      checkOutput("mid_rst_err_cnt", int'(err_cnt), 0);
      repeat (30) @(posedge wave_clk);
      #1 wave_rst = 1'b1;
      repeat (int'(DIV) * 3) @(posedge wave_clk);
      checkOutput("post_rst_no_start", start_cnt, target);
      checkOutput("post_rst_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
